byte_fifo_stage: RTL and testbench
==================================

// Module: byte_fifo_stage
// PURPOSE
//  Buffered byte source placed directly upstream of the 8-bit register stage.
//  Accepts bytes on a valid/ready input port and stores up to DEPTH of them in a
//  show-ahead FIFO. Presents the oldest stored byte on dout, which drives the
//  register stage's din.
//  Absorbs producer bursts so the register stage sees a steady, back-pressurable stream.
// PARAMETERS
//  WIDTH   8   data width in bits
//  DEPTH   4   number of entries; power of two, >= 2
//  CNT_W   3   count width = $clog2(DEPTH+1)
// PORTS
//  clk       input   1      single clock; all state updates on rising edge
//  rst_n     input   1      asynchronous, active-low reset
//  flush     input   1      synchronous clear of all entries; overrides push/pop
//  in_valid  input   1      producer has a byte on din
//  din       input   WIDTH  producer data
//  in_ready  output  1      FIFO can accept a byte this cycle
//  out_valid output  1      dout holds a valid byte
//  dout      output  WIDTH  oldest stored byte (feeds register stage din)
//  out_ready input   1      consumer takes dout this cycle
//  count     output  CNT_W  number of stored entries, 0..DEPTH
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
//  - State: mem[DEPTH], wr_ptr and rd_ptr of $clog2(DEPTH) bits each, and count.
//  - Reset (rst_n=0, async):
//    - wr_ptr=0, rd_ptr=0, count=0.
//    - Outputs: in_ready=1, out_valid=0, dout=0.
//    - mem is not reset.
//  - Handshake flags (combinational from state only; no input-to-output paths):
//    - in_ready  = (count != DEPTH)
//    - out_valid = (count != 0)
//  - Transfers:
//    - push = in_valid & in_ready
//    - pop  = out_valid & out_ready
//  - Push: mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH (natural wrap).
//  - Pop: rd_ptr increments modulo DEPTH.
//  - Count update:
//    - +1 on push only
//    - -1 on pop only
//    - unchanged on simultaneous push+pop (legal at any 0<count<DEPTH)
//  - dout:
//    - dout = mem[rd_ptr] when out_valid=1.
//    - dout is forced to 0 when out_valid=0, so the register stage never samples stale memory.
//  - Latency: a byte pushed in cycle N is visible on dout/out_valid in cycle N+1 when the FIFO was empty.
//  - Ordering: strict FIFO. No byte is lost or duplicated.
//  - Full (count=DEPTH): in_ready=0; in_valid is ignored; a pop this cycle frees a slot for cycle N+1.
//  - Empty (count=0): out_valid=0; out_ready is ignored; a push and a pop never coincide.
//  - flush=1 at an edge:
//    - pointers and count go to 0 regardless of push/pop.
//    - A byte offered in the same cycle is discarded.
//  - Reset mid-operation: all contents abandoned immediately (async); outputs at reset values while rst_n=0.
//  - Producer protocol: din/in_valid may change freely while in_ready=0.
//  - Consumer protocol: dout and out_valid stay stable until popped or flushed.
// TESTING
//  1 Reset: assert rst_n=0 with the FIFO holding 2 bytes -> immediately out_valid=0,
//    dout=8'h00, count=0, in_ready=1.
//  2 Fill/drain: push 8'hA1,8'hB2,8'hC3,8'hD4 with out_ready=0 -> count=4, in_ready=0;
//    a 5th push of 8'hE5 is ignored; then out_ready=1 -> A1,B2,C3,D4 in order, then out_valid=0.
//  3 Simultaneous: count=2 holding {11,22}; push 33 with pop in the same cycle -> count stays 2;
//    dout=22 next cycle, then 33.
//  4 Wrap: stream 10 bytes 8'h00..8'h09 with random in_valid/out_ready, pointers wrapping twice ->
//    output sequence 00..09 exact; count never exceeds 4.
//  5 Full + pop: at count=4 with in_valid=1 and out_ready=1 -> pop only, count=3;
//    the push is accepted next cycle (count back to 4).
//  6 Flush: count=3, flush=1 with in_valid=1 (din=8'h5A) -> count=0, out_valid=0 next cycle;
//    8'h5A is never output.

Source files
------------

// File: rtl/byte_fifo_stage.sv
// byte_fifo_stage
//   Show-ahead byte FIFO sitting directly upstream of the 8-bit register stage.
//   Producer bursts are absorbed here so the register stage sees a steady,
//   back-pressurable stream. The oldest stored byte is always presented on dout.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of all entries, overrides push and pop
//   in_valid   producer has a byte on din
//   din        producer data
//   in_ready   FIFO can accept a byte this cycle
//   out_valid  dout holds a valid byte
//   dout       oldest stored byte, zero while empty
//   out_ready  consumer takes dout this cycle
//   count      number of stored entries, 0..DEPTH
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready and out_valid depend on stored state only, never on in_valid
// or out_ready, so there is no combinational path from input to output. The
// producer may change din/in_valid freely while in_ready is low; dout and
// out_valid hold steady until popped or flushed.

module byte_fifo_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Forced to zero while empty so the register stage never samples stale memory.
    assign dout = out_valid ? mem[rd_ptr] : '0;

    // Storage is not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_byte_fifo_stage.sv
module tb_byte_fifo_stage;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] din;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] dout;
    logic       out_ready;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];

    byte_fifo_stage #(.WIDTH(8), .DEPTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .din       (din),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .dout      (dout),
        .out_ready (out_ready),
        .count     (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        din      = b;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int rx;
        int tx;
        int cyc;
        bit model_push;
        bit model_pop;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        din       = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        check("reset_count", count, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_dout", dout, 8'h00);
        rst_n = 1'b1;
        step();

        // 1: async reset while holding two bytes
        push_byte(8'h77);
        push_byte(8'h88);
        check("t1_count_before", count, 2);
        check("t1_dout_before", dout, 8'h77);
        rst_n = 1'b0;
        #1;
        check("t1_out_valid", out_valid, 0);
        check("t1_dout", dout, 8'h00);
        check("t1_count", count, 0);
        check("t1_in_ready", in_ready, 1);
        #1;
        rst_n = 1'b1;
        step();

        // 2: fill / overflow attempt / drain
        push_byte(8'hA1);
        check("t2_latency_valid", out_valid, 1);
        check("t2_latency_dout", dout, 8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        push_byte(8'hD4);
        check("t2_full_count", count, 4);
        check("t2_full_in_ready", in_ready, 0);
        push_byte(8'hE5);
        check("t2_ignored_count", count, 4);
        check("t2_ignored_head", dout, 8'hA1);
        out_ready = 1'b1;
        check("t2_pop0", dout, 8'hA1);
        step();
        check("t2_pop1", dout, 8'hB2);
        step();
        check("t2_pop2", dout, 8'hC3);
        step();
        check("t2_pop3", dout, 8'hD4);
        step();
        check("t2_empty_valid", out_valid, 0);
        check("t2_empty_dout", dout, 8'h00);
        check("t2_empty_count", count, 0);
        step();
        check("t2_empty_pop_ignored", count, 0);
        out_ready = 1'b0;

        // 3: simultaneous push and pop at count=2
        push_byte(8'h11);
        push_byte(8'h22);
        check("t3_count2", count, 2);
        check("t3_head", dout, 8'h11);
        in_valid  = 1'b1;
        din       = 8'h33;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("t3_count_same", count, 2);
        check("t3_dout22", dout, 8'h22);
        step();
        check("t3_dout33", dout, 8'h33);
        check("t3_count1", count, 1);
        step();
        check("t3_count0", count, 0);
        out_ready = 1'b0;

        // 4: random-throttled stream of 00..09 with pointer wrap
        rx  = 0;
        tx  = 0;
        cyc = 0;
        exp_q.delete();
        while (rx < 10 && cyc < 500) begin
            in_valid  = (tx < 10) && ($urandom_range(0, 1) == 1);
            din       = 8'(tx);
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            model_push = in_valid && (exp_q.size() < 4);
            model_pop  = out_ready && (exp_q.size() > 0);
            check("t4_in_ready", in_ready, (exp_q.size() < 4) ? 1 : 0);
            check("t4_out_valid", out_valid, (exp_q.size() > 0) ? 1 : 0);
            if (model_pop) begin
                check("t4_dout", dout, exp_q[0]);
                check("t4_order", dout, rx);
            end
            step();
            if (model_pop) begin
                void'(exp_q.pop_front());
                rx++;
            end
            if (model_push) begin
                exp_q.push_back(8'(tx));
                tx++;
            end
            check("t4_count", count, exp_q.size());
            if (count > 3'd4) begin
                check("t4_count_bound", count, 4);
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t4_all_received", rx, 10);
        check("t4_final_empty", count, 0);

        // 5: full with push and pop offered together
        push_byte(8'h40);
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        check("t5_full", count, 4);
        in_valid  = 1'b1;
        din       = 8'h44;
        out_ready = 1'b1;
        #1;
        check("t5_in_ready_low", in_ready, 0);
        step();
        check("t5_pop_only_count", count, 3);
        check("t5_head41", dout, 8'h41);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("t5_push_next", count, 4);

        // 6: flush with a byte offered in the same cycle
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t6_count3", count, 3);
        flush    = 1'b1;
        in_valid = 1'b1;
        din      = 8'h5A;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t6_count0", count, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_dout", dout, 8'h00);
        out_ready = 1'b1;
        step();
        check("t6_no_5a", out_valid, 0);
        out_ready = 1'b0;
        push_byte(8'h66);
        check("t6_after_flush_dout", dout, 8'h66);
        check("t6_after_flush_count", count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
